ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Shares the single RAMControl port (instruction/latch/addr/data/ready) between NUM_REQ
//  requesters (Network evaluation, NetworkControl sort/crossover, init loader).
//  Round-robin arbitration, one 16-bit access per grant, optional lock for read-modify-write.
//  Sequences the RAMControl latch/ready handshake and returns read data and completion to the winner.
// PARAMETERS
//  NUM_REQ   3      number of requesters (2..8)
//  TIMEOUT   255    max cycles waited in WAIT_LOW or WAIT_HIGH before forced completion
//  CNT_W     8      width of timeout counter (2**CNT_W > TIMEOUT)
// PORTS
//  clk        in   1            system clock, all logic on posedge
//  rst_n      in   1            asynchronous active-low reset
//  req        in   NUM_REQ      per-requester access request, level, held until ack
//  lock       in   NUM_REQ      keep grant after this access (sampled with ack)
//  we         in   NUM_REQ      1=WRITE, 0=READ, per requester
//  addr       in   NUM_REQ*23   packed word addresses [23:1], requester i at [23*i+:23]
//  wdata      in   NUM_REQ*16   packed write data, requester i at [16*i+:16]
//  ack        out  NUM_REQ      one-cycle completion pulse to granted requester
//  rdata      out  16           read data, valid in ack cycle, held until next read completes
//  grant      out  NUM_REQ      one-hot current owner, 0 when idle
//  ram_instr  out  1            to RAMControl instruction: READ=0, WRITE=1
//  ram_latch  out  1            to RAMControl latch, one-cycle pulse
//  ram_addr   out  23           to RAMControl address
//  ram_wdata  out  16           to RAMControl data in
//  ram_rdata  in   16           from RAMControl data out
//  ram_ready  in   1            from RAMControl, 1 = idle/access done
//  busy       out  1            1 in any state other than IDLE
//  timeout_err out 1            sticky, set on any timeout, cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0, state=IDLE, last-winner pointer=NUM_REQ-1 (req[0] wins first).
//  RAMControl has no reset: after rst_n release, no access issues until ram_ready=1.
//  States: IDLE -> ISSUE -> WAIT_LOW -> WAIT_HIGH -> DONE -> IDLE (or ISSUE if locked).
//  IDLE: if ram_ready=1 and |req, pick first req set scanning from pointer+1 modulo NUM_REQ;
//    register grant, ram_addr, ram_wdata, ram_instr from winner; pointer<=winner; go ISSUE.
//  ISSUE: ram_latch=1 for exactly this cycle; counter cleared; go WAIT_LOW.
//  WAIT_LOW: wait for ram_ready=0 (RAMControl accepted); then WAIT_HIGH, counter cleared.
//  WAIT_HIGH: wait for ram_ready=1; on it, capture ram_rdata into rdata if read; go DONE.
//  Timeout: counter increments each WAIT_LOW/WAIT_HIGH cycle; at TIMEOUT, set timeout_err,
//    go DONE without updating rdata.
//  DONE: ack[winner]=1 one cycle. If lock[winner]=1 and req[winner]=1 next-cycle data is
//    taken: stay granted, reload addr/wdata/instr from winner, go ISSUE (no re-arbitration).
//    Otherwise grant<=0, go IDLE. Requester must drop or refresh req the cycle after ack.
//  Min latency req->ack: 5 cycles (IDLE,ISSUE,WAIT_LOW,WAIT_HIGH,DONE) with 1-cycle ready drop.
//  Back-to-back: IDLE re-arbitration costs 1 cycle; locked follow-on skips IDLE.
//  req deasserted while granted (illegal): access completes, ack still pulses, no abort.
//  Inputs of non-granted requesters ignored; ram_addr/wdata/instr stable ISSUE..DONE.
//  Lock by a requester never starves others beyond its lock run; pointer advances on release.
//  rst_n low mid-access: immediate return to IDLE, outputs cleared; in-flight RAM op abandoned.
//  ram_latch never asserted outside ISSUE; at most one RAM access outstanding.
// TESTING
//  req=3'b111 all reads, ram model ready drops 1 cycle after latch for 2 cycles -> grants 0,1,2,0 in order, each ack 5 cycles after issue start.
//  req[1] write addr=23'h000010 wdata=16'hBEEF -> one ram_latch pulse, ram_instr=1, ram_addr=23'h10, ram_wdata=16'hBEEF, ack[1] once.
//  req[2] read with lock=1 then write same addr, req[0] pending -> req[2] gets both accesses before grant[0]; rdata=model value.
//  ram_ready held 1 after latch -> after 255 wait cycles timeout_err=1, ack pulses, arbiter returns IDLE and serves next req.
//  rst_n pulsed low during WAIT_HIGH -> all outputs 0 next edge; with ram_ready=0 after release, no latch until ram_ready=1.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bundles the requester-side and RAMControl-side signals of the RAM arbiter.
// slave = arbiter view, master = requesters plus RAMControl view.
interface ram_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    lock;
  logic [NUM_REQ-1:0]    we;
  logic [NUM_REQ*23-1:0] addr;
  logic [NUM_REQ*16-1:0] wdata;
  logic [NUM_REQ-1:0]    ack;
  logic [15:0]           rdata;
  logic [NUM_REQ-1:0]    grant;
  logic                  ram_instr;
  logic                  ram_latch;
  logic [22:0]           ram_addr;
  logic [15:0]           ram_wdata;
  logic [15:0]           ram_rdata;
  logic                  ram_ready;
  logic                  busy;
  logic                  timeout_err;

  modport slave (
    input  req, lock, we, addr, wdata, ram_rdata, ram_ready,
    output ack, rdata, grant, ram_instr, ram_latch, ram_addr, ram_wdata, busy, timeout_err
  );

  modport master (
    output req, lock, we, addr, wdata, ram_rdata, ram_ready,
    input  ack, rdata, grant, ram_instr, ram_latch, ram_addr, ram_wdata, busy, timeout_err
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAMControl port; req->ack min 5 cycles, held req is the only
// backpressure (requests wait in IDLE until ram_ready=1 and the pointer reaches them).
module ram_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  ram_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [IDX_W-1:0]   win, win_nxt;
  logic [NUM_REQ-1:0] grant, grant_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               instr, instr_nxt;
  logic [22:0]        addr_q, addr_nxt;
  logic [15:0]        wdata_q, wdata_nxt;
  logic [15:0]        rdata_q, rdata_nxt;
  logic               err, err_nxt;

  logic               found;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   cand;
  int                 cidx;
  logic [IDX_W-1:0]   sel;
  logic [22:0]        sel_addr;
  logic [15:0]        sel_wdata;
  logic               sel_we;

  // Scan starts just after the last winner, so the previous owner is checked last.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    cand  = '0;
    cidx  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cidx = int'(ptr) + k;
      if (cidx >= NUM_REQ) begin
        cidx = cidx - NUM_REQ;
      end
      cand = IDX_W'(cidx);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Operand source: the arbitration pick while idle, otherwise the current owner (lock reload).
  assign sel = (state == IDLE) ? pick : win;

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (IDX_W'(k) == sel) begin
        sel_addr  = bus.addr[k*23 +: 23];
        sel_wdata = bus.wdata[k*16 +: 16];
        sel_we    = bus.we[k];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    win_nxt   = win;
    grant_nxt = grant;
    cnt_nxt   = cnt;
    instr_nxt = instr;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    rdata_nxt = rdata_q;
    err_nxt   = err;
    case (state)
      IDLE: begin
        if (bus.ram_ready && found) begin
          win_nxt         = pick;
          ptr_nxt         = pick;
          grant_nxt       = '0;
          grant_nxt[pick] = 1'b1;
          instr_nxt       = sel_we;
          addr_nxt        = sel_addr;
          wdata_nxt       = sel_wdata;
          state_nxt       = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!bus.ram_ready) begin
          cnt_nxt   = '0;
          state_nxt = WAIT_HIGH;
        end else if (cnt == CNT_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (bus.ram_ready) begin
          if (!instr) begin
            rdata_nxt = bus.ram_rdata;
          end
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        // A locked owner presents its follow-on access alongside the ack cycle.
        if (bus.lock[win] && bus.req[win]) begin
          instr_nxt = sel_we;
          addr_nxt  = sel_addr;
          wdata_nxt = sel_wdata;
          state_nxt = ISSUE;
        end else begin
          grant_nxt = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= IDX_W'(NUM_REQ - 1);
      win     <= '0;
      grant   <= '0;
      cnt     <= '0;
      instr   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      win     <= win_nxt;
      grant   <= grant_nxt;
      cnt     <= cnt_nxt;
      instr   <= instr_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      rdata_q <= rdata_nxt;
      err     <= err_nxt;
    end
  end

  assign bus.grant       = grant;
  assign bus.ack         = (state == DONE) ? grant : '0;
  assign bus.ram_latch   = (state == ISSUE);
  assign bus.busy        = (state != IDLE);
  assign bus.ram_instr   = instr;
  assign bus.ram_addr    = addr_q;
  assign bus.ram_wdata   = wdata_q;
  assign bus.rdata       = rdata_q;
  assign bus.timeout_err = err;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: requester queues and a RAMControl model drive the DUT,
// a scoreboard of expected acks (owner, rdata, latency, spacing) is checked on each ack.
module tb_ram_arbiter;
  localparam int N  = 3;
  localparam int TO = 255;

  typedef struct {
    logic        we;
    logic        lock;
    logic [22:0] addr;
    logic [15:0] wdata;
  } op_t;

  typedef struct {
    int          idx;
    logic        is_rd;
    logic [15:0] rd;
    int          lat;
    int          gap;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if #(.NUM_REQ(N)) bus ();

  ram_arbiter #(.NUM_REQ(N), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   nvec  = 0;
  int   nfail = 0;
  op_t  rq [N][$];
  exp_t sb [$];

  logic [15:0] mem    [256];
  logic [15:0] shadow [256];
  int   low_len   = 2;
  int   low_cnt   = 0;
  bit   skip_next = 1'b0;
  bit   force_low = 1'b0;

  int   cyc = 0, latch_cyc = 0, last_ack = 0, latches_since = 0, latch_total = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(int k);
    logic [N-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic present(int i);
    if (rq[i].size() > 0) begin
      bus.req[i]            = 1'b1;
      bus.we[i]             = rq[i][0].we;
      bus.lock[i]           = rq[i][0].lock;
      bus.addr[23*i +: 23]  = rq[i][0].addr;
      bus.wdata[16*i +: 16] = rq[i][0].wdata;
    end else begin
      bus.req[i]  = 1'b0;
      bus.lock[i] = 1'b0;
    end
  endtask

  task automatic enq(int i, logic w, logic lk, logic [22:0] a, logic [15:0] d);
    op_t o;
    o.we = w; o.lock = lk; o.addr = a; o.wdata = d;
    rq[i].push_back(o);
    if (w) shadow[a[7:0]] = d;
    if (rq[i].size() == 1) present(i);
  endtask

  task automatic expect_ack(int i, logic rd, logic [15:0] v, int lat, int gap);
    exp_t e;
    e.idx = i; e.is_rd = rd; e.rd = v; e.lat = lat; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drain(string tag, int limit);
    int c;
    c = 0;
    while ((sb.size() > 0 || bus.busy) && c < limit) begin
      @(posedge clk);
      c++;
    end
    step(2);
    chk(tag, 64'(sb.size()), 64'(0));
  endtask

  // RAMControl model: ready drops after an accepted latch for low_len cycles.
  always @(posedge clk) begin
    if (low_cnt > 0) low_cnt--;
    if (bus.ram_latch) begin
      if (skip_next) begin
        skip_next = 1'b0;
      end else begin
        if (bus.ram_instr) mem[bus.ram_addr[7:0]] = bus.ram_wdata;
        else bus.ram_rdata <= mem[bus.ram_addr[7:0]];
        low_cnt = low_len;
      end
    end
    if (force_low) low_cnt = 0;
    bus.ram_ready <= !force_low && (low_cnt == 0);
  end

  // Monitor and requester driver; samples on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      latches_since = 0;
    end else begin
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (!bus.ack[i] && rq[i].size() > 0) bus.lock[i] = rq[i][0].lock;
      end
      if (bus.ram_latch) begin
        latch_cyc = cyc;
        latches_since++;
        latch_total++;
        if (sb.size() > 0) begin
          int k;
          k = sb[0].idx;
          chk("latch_grant", 64'(bus.grant), 64'(onehot(k)));
          if (rq[k].size() > 0) begin
            chk("latch_instr", 64'(bus.ram_instr), 64'(rq[k][0].we));
            chk("latch_addr", 64'(bus.ram_addr), 64'(rq[k][0].addr));
            if (rq[k][0].we) chk("latch_wdata", 64'(bus.ram_wdata), 64'(rq[k][0].wdata));
          end
        end
      end
      if (bus.ack != '0) begin
        int j;
        op_t done_op;
        j = 0;
        for (int i = N - 1; i >= 0; i--) if (bus.ack[i]) j = i;
        if (sb.size() == 0) begin
          chk("ack_unexpected", 64'(bus.ack), 64'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_owner", 64'(bus.ack), 64'(onehot(e.idx)));
          if (e.is_rd) chk("ack_rdata", 64'(bus.rdata), 64'(e.rd));
          if (e.lat >= 0) chk("ack_latency", 64'(cyc - latch_cyc), 64'(e.lat));
          if (e.gap >= 0) chk("ack_gap", 64'(cyc - last_ack), 64'(e.gap));
          chk("latch_per_ack", 64'(latches_since), 64'(1));
        end
        latches_since = 0;
        last_ack = cyc;
        if (rq[j].size() > 0) begin
          done_op = rq[j].pop_front();
          present(j);
          bus.lock[j] = done_op.lock;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lt;
    int c;
    bus.req = '0; bus.lock = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    bus.ram_ready = 1'b0; bus.ram_rdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 16'hA000 | 16'(i);
      shadow[i] = 16'hA000 | 16'(i);
    end

    // Reset values
    step(3);
    chk("rst_grant", 64'(bus.grant), 64'(0));
    chk("rst_ack", 64'(bus.ack), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_latch", 64'(bus.ram_latch), 64'(0));
    chk("rst_rdata", 64'(bus.rdata), 64'(0));
    chk("rst_terr", 64'(bus.timeout_err), 64'(0));
    rst_n = 1'b1;
    step(2);

    // All three read, req0 queues a second read: grants 0,1,2,0
    low_len = 2;
    enq(0, 1'b0, 1'b0, 23'h1, 16'h0);
    enq(1, 1'b0, 1'b0, 23'h2, 16'h0);
    enq(2, 1'b0, 1'b0, 23'h3, 16'h0);
    enq(0, 1'b0, 1'b0, 23'h4, 16'h0);
    expect_ack(0, 1'b1, shadow[1], 4, -1);
    expect_ack(1, 1'b1, shadow[2], 4, 6);
    expect_ack(2, 1'b1, shadow[3], 4, 6);
    expect_ack(0, 1'b1, shadow[4], 4, 6);
    drain("drain_rr", 200);

    // Write from req1, then read back by req0
    low_len = 1;
    lt = latch_total;
    enq(1, 1'b1, 1'b0, 23'h10, 16'hBEEF);
    enq(0, 1'b0, 1'b0, 23'h10, 16'h0);
    expect_ack(1, 1'b0, 16'h0, 3, -1);
    expect_ack(0, 1'b1, 16'hBEEF, 3, 5);
    drain("drain_wr", 200);
    chk("wr_mem", 64'(mem[8'h10]), 64'(16'hBEEF));
    chk("wr_latches", 64'(latch_total - lt), 64'(2));

    // Locked read-modify-write by req2 ahead of req0
    low_len = 2;
    enq(2, 1'b0, 1'b1, 23'h20, 16'h0);
    enq(2, 1'b1, 1'b0, 23'h20, 16'h1234);
    enq(0, 1'b0, 1'b0, 23'h21, 16'h0);
    enq(0, 1'b0, 1'b0, 23'h20, 16'h0);
    expect_ack(2, 1'b1, 16'hA020, 4, -1);
    expect_ack(2, 1'b0, 16'h0, 4, 5);
    expect_ack(0, 1'b1, shadow[8'h21], 4, 6);
    expect_ack(0, 1'b1, 16'h1234, 4, 6);
    drain("drain_lock", 200);
    chk("lock_terr_clear", 64'(bus.timeout_err), 64'(0));

    // Timeout: RAM ignores req1's latch; rdata keeps last read value
    skip_next = 1'b1;
    enq(1, 1'b0, 1'b0, 23'h30, 16'h0);
    enq(2, 1'b0, 1'b0, 23'h31, 16'h0);
    expect_ack(1, 1'b1, 16'h1234, TO + 1, -1);
    expect_ack(2, 1'b1, shadow[8'h31], 4, 6);
    drain("drain_timeout", 600);
    chk("timeout_err_set", 64'(bus.timeout_err), 64'(1));

    // Reset during WAIT_HIGH, then RAMControl stays not-ready after release
    low_len = 10;
    lt = latch_total;
    enq(0, 1'b0, 1'b0, 23'h5, 16'h0);
    c = 0;
    while (latch_total == lt && c < 50) begin
      @(posedge clk);
      c++;
    end
    chk("rst_latch_seen", 64'(latch_total != lt), 64'(1));
    step(2);
    rst_n = 1'b0;
    force_low = 1'b1;
    sb.delete();
    for (int i = 0; i < N; i++) rq[i].delete();
    bus.req = '0;
    bus.lock = '0;
    #1;
    chk("mid_rst_grant", 64'(bus.grant), 64'(0));
    chk("mid_rst_busy", 64'(bus.busy), 64'(0));
    chk("mid_rst_ack", 64'(bus.ack), 64'(0));
    chk("mid_rst_latch", 64'(bus.ram_latch), 64'(0));
    chk("mid_rst_rdata", 64'(bus.rdata), 64'(0));
    chk("mid_rst_terr", 64'(bus.timeout_err), 64'(0));
    chk("mid_rst_addr", 64'(bus.ram_addr), 64'(0));
    step(1);
    rst_n = 1'b1;
    low_len = 1;
    lt = latch_total;
    enq(2, 1'b0, 1'b0, 23'h6, 16'h0);
    expect_ack(2, 1'b1, shadow[6], 3, -1);
    step(10);
    chk("no_latch_not_ready", 64'(latch_total - lt), 64'(0));
    chk("idle_not_ready", 64'(bus.busy), 64'(0));
    force_low = 1'b0;
    drain("drain_after_rst", 200);
    chk("after_rst_latches", 64'(latch_total - lt), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
